fu_driver: RTL and testbench
============================

FU_DRIVER -- requirements
Module: fu_driver

Interface
REQ-001 SHALL have parameter FS_ADD, default 4'b0000, FunctionUnit code for A+B.
REQ-002 SHALL have parameter FS_SUB, default 4'b1000, FunctionUnit code for A-B (C=1 means no borrow).
REQ-003 SHALL have parameters FS_AND/FS_OR/FS_XOR, defaults 4'b0010/4'b0110/4'b1010, bitwise codes.
REQ-004 SHALL have parameters FS_SLL/FS_SRL/FS_SRA, defaults 4'b0001/4'b0101/4'b1001, shifter codes.
REQ-005 clk  in  1  sole clock, rising edge; reset is synchronous and active-high.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  op request; in_ready  out  1  block can accept.
REQ-008 funct3  in  3, funct7_b5  in  1, is_imm  in  1  RISC-V OP/OP-IMM fields.
REQ-009 rs1_val  in  32, rs2_val  in  32, imm  in  32 (sign-extended), rd  in  5.
REQ-010 fu_a  out  32, fu_b  out  32, fu_fs  out  4  drive the combinational FunctionUnit.
REQ-011 fu_result  in  32, fu_z/fu_c/fu_v  in  1 each  FunctionUnit outputs, same cycle.
REQ-012 out_valid  out  1, out_ready  in  1, out_rd  out  5, out_data  out  32, out_flags  out  3 {Z,C,V}, out_err  out  1.

Function
REQ-013 States IDLE, EXEC, CMP, DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 Accept when in_valid&&in_ready: latch A=rs1_val, B=(is_imm?imm:rs2_val), rd, decoded FS, op class; go EXEC.
REQ-015 Decode: 000 ADD (SUB if !is_imm&&funct7_b5); 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL/SRA by funct7_b5; 110 OR; 111 AND.
REQ-016 SLT/SLTU SHALL issue FS_SUB.
REQ-017 Shifts SHALL drive fu_b={27'b0,B[4:0]}; all other ops drive fu_b=B unchanged.
REQ-018 Illegal: !is_imm && funct7_b5 && funct3 not in {000,101}; also is_imm && funct3=001 && funct7_b5.
REQ-019 In EXEC, fu_a/fu_b/fu_fs SHALL present latched operands; in all other states they SHALL be 0.
REQ-020 EXEC end, non-compare: capture fu_result to out_data, {fu_z,fu_c,fu_v} to out_flags; go DONE.
REQ-021 EXEC end, SLT/SLTU: capture flags and fu_result[31]; go CMP.
REQ-022 CMP: out_data = {31'b0, N^V} for SLT, {31'b0, ~C} for SLTU; out_flags = captured SUB flags; go DONE.
REQ-023 Illegal op: pass EXEC with FU inputs 0, out_data=0, out_flags=0, out_err=1; go DONE.
REQ-024 Latency accept->out_valid: 2 cycles normal/illegal, 3 cycles SLT/SLTU.
REQ-025 DONE: out_valid=1; out_rd/out_data/out_flags/out_err held stable until out_valid&&out_ready.
REQ-026 On output handshake go IDLE; no new accept in that same cycle (one op in flight, max throughput 1 per 3 cycles).
REQ-027 out_err SHALL be 0 for all legal ops.

Reset
REQ-028 rst SHALL force IDLE, out_valid=0, out_data=0, out_flags=0, out_err=0, out_rd=0, fu_a/fu_b/fu_fs=0, in_ready=1 on the next edge.
REQ-029 rst in any state, including mid-EXEC/CMP or DONE with out_ready low, SHALL discard the op; no out_valid is produced for it.
REQ-030 rst SHALL take priority over a simultaneous in_valid or out_ready.

Verification
REQ-031 ADD rs1=0xFFFFFFFF rs2=1 -> out_valid 2 cycles after accept, out_data=0, Z=1, C=1.
REQ-032 SLT rs1=0x80000000 rs2=1 -> out_data=1 at 3 cycles; SLTU same operands -> out_data=0.
REQ-033 SRAI A=0x80000000 imm=0x00000404 (funct7_b5=1) -> fu_b=4 in EXEC, out_data=0xF8000000.
REQ-034 Illegal reg op funct3=100 funct7_b5=1 -> out_err=1, out_data=0, fu_fs=0 during EXEC.
REQ-035 out_ready low 5 cycles in DONE -> outputs stable, in_ready=0 throughout; accept resumes the cycle after handshake.
REQ-036 rst asserted during CMP -> next cycle IDLE, out_valid=0, in_ready=1, no output for that op.

Source files
------------

// File: rtl/fu_driver_if.sv
// fu_driver request/response bundle.
// Op request handshake in, result handshake out.
interface fu_driver_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  funct3;
   logic        funct7_b5;
   logic        is_imm;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [31:0] imm;
   logic [4:0]  rd;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  out_rd;
   logic [31:0] out_data;
   logic [2:0]  out_flags;
   logic        out_err;

   modport slave (
      input  in_valid, funct3, funct7_b5, is_imm,
      input  rs1_val, rs2_val, imm, rd, out_ready,
      output in_ready, out_valid, out_rd, out_data,
      output out_flags, out_err
   );

   modport master (
      output in_valid, funct3, funct7_b5, is_imm,
      output rs1_val, rs2_val, imm, rd, out_ready,
      input  in_ready, out_valid, out_rd, out_data,
      input  out_flags, out_err
   );
endinterface

// File: rtl/fu_driver.sv
// Sequences one RISC-V OP/OP-IMM instruction through an
// external combinational FunctionUnit, one op in flight.
module fu_driver #(
   parameter logic [3:0] FS_ADD = 4'b0000,
   parameter logic [3:0] FS_SUB = 4'b1000,
   parameter logic [3:0] FS_AND = 4'b0010,
   parameter logic [3:0] FS_OR  = 4'b0110,
   parameter logic [3:0] FS_XOR = 4'b1010,
   parameter logic [3:0] FS_SLL = 4'b0001,
   parameter logic [3:0] FS_SRL = 4'b0101,
   parameter logic [3:0] FS_SRA = 4'b1001
) (
   input  logic        clk,
   input  logic        rst,
   fu_driver_if.slave  bus,
   output logic [31:0] fu_a,
   output logic [31:0] fu_b,
   output logic [3:0]  fu_fs,
   input  logic [31:0] fu_result,
   input  logic        fu_z,
   input  logic        fu_c,
   input  logic        fu_v
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] CMP  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]  r_state;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [3:0]  r_fs;
   logic [4:0]  r_rd;
   logic        r_slt;
   logic        r_sltu;
   logic        r_shift;
   logic        r_ill;
   logic        r_n;
   logic [31:0] r_data;
   logic [2:0]  r_flags;
   logic        r_err;

   logic [3:0]  w_fs;
   logic        w_slt;
   logic        w_sltu;
   logic        w_shift;
   logic        w_ill;
   logic        w_exec;

   always_comb begin
      w_fs    = FS_ADD;
      w_slt   = 1'b0;
      w_sltu  = 1'b0;
      w_shift = 1'b0;
      unique case (bus.funct3)
         3'b000: w_fs = (!bus.is_imm && bus.funct7_b5) ? FS_SUB : FS_ADD;
         3'b001: begin
            w_fs    = FS_SLL;
            w_shift = 1'b1;
         end
         3'b010: begin
            w_fs  = FS_SUB;
            w_slt = 1'b1;
         end
         3'b011: begin
            w_fs   = FS_SUB;
            w_sltu = 1'b1;
         end
         3'b100: w_fs = FS_XOR;
         3'b101: begin
            w_fs    = bus.funct7_b5 ? FS_SRA : FS_SRL;
            w_shift = 1'b1;
         end
         3'b110: w_fs = FS_OR;
         3'b111: w_fs = FS_AND;
         default: w_fs = FS_ADD;
      endcase
      w_ill = (!bus.is_imm && bus.funct7_b5 &&
               bus.funct3 != 3'b000 && bus.funct3 != 3'b101) ||
              (bus.is_imm && bus.funct3 == 3'b001 && bus.funct7_b5);
      // Illegal ops run with a zeroed FS so nothing odd hits the unit.
      if (w_ill) begin
         w_fs    = 4'b0000;
         w_slt   = 1'b0;
         w_sltu  = 1'b0;
         w_shift = 1'b0;
      end
   end

   assign w_exec = (r_state == EXEC) && !r_ill;

   assign fu_a  = w_exec ? r_a : 32'd0;
   assign fu_b  = !w_exec ? 32'd0 :
                  r_shift ? {27'd0, r_b[4:0]} : r_b;
   assign fu_fs = w_exec ? r_fs : 4'd0;

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == DONE);
   assign bus.out_rd    = r_rd;
   assign bus.out_data  = r_data;
   assign bus.out_flags = r_flags;
   assign bus.out_err   = r_err;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_a     <= 32'd0;
         r_b     <= 32'd0;
         r_fs    <= 4'd0;
         r_rd    <= 5'd0;
         r_slt   <= 1'b0;
         r_sltu  <= 1'b0;
         r_shift <= 1'b0;
         r_ill   <= 1'b0;
         r_n     <= 1'b0;
         r_data  <= 32'd0;
         r_flags <= 3'd0;
         r_err   <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (bus.in_valid) begin
                  r_a     <= bus.rs1_val;
                  r_b     <= bus.is_imm ? bus.imm : bus.rs2_val;
                  r_fs    <= w_fs;
                  r_rd    <= bus.rd;
                  r_slt   <= w_slt;
                  r_sltu  <= w_sltu;
                  r_shift <= w_shift;
                  r_ill   <= w_ill;
                  r_state <= EXEC;
               end
            end
            EXEC: begin
               if (r_ill) begin
                  r_data  <= 32'd0;
                  r_flags <= 3'd0;
                  r_err   <= 1'b1;
                  r_state <= DONE;
               end else if (r_slt || r_sltu) begin
                  r_flags <= {fu_z, fu_c, fu_v};
                  r_n     <= fu_result[31];
                  r_err   <= 1'b0;
                  r_state <= CMP;
               end else begin
                  r_data  <= fu_result;
                  r_flags <= {fu_z, fu_c, fu_v};
                  r_err   <= 1'b0;
                  r_state <= DONE;
               end
            end
            CMP: begin
               // flags are {Z,C,V}: signed uses N^V, unsigned uses borrow
               r_data  <= {31'd0, r_slt ? (r_n ^ r_flags[0]) : ~r_flags[1]};
               r_state <= DONE;
            end
            DONE: begin
               if (bus.out_ready)
                  r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fu_driver.sv
// Directed self-checking bench for fu_driver with a
// behavioural FunctionUnit model attached.
module tb_fu_driver;

   logic        clk;
   logic        rst;
   logic [31:0] fu_a;
   logic [31:0] fu_b;
   logic [3:0]  fu_fs;
   logic [31:0] fu_result;
   logic        fu_z;
   logic        fu_c;
   logic        fu_v;

   int total;
   int bad;

   fu_driver_if bus();

   fu_driver dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .fu_a      (fu_a),
      .fu_b      (fu_b),
      .fu_fs     (fu_fs),
      .fu_result (fu_result),
      .fu_z      (fu_z),
      .fu_c      (fu_c),
      .fu_v      (fu_v)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural FunctionUnit: C on SUB means no borrow.
   always_comb begin
      logic [32:0] t;
      t         = 33'd0;
      fu_result = 32'd0;
      fu_c      = 1'b0;
      fu_v      = 1'b0;
      case (fu_fs)
         4'b0000: begin
            t         = {1'b0, fu_a} + {1'b0, fu_b};
            fu_result = t[31:0];
            fu_c      = t[32];
            fu_v      = (fu_a[31] == fu_b[31]) && (t[31] != fu_a[31]);
         end
         4'b1000: begin
            fu_result = fu_a - fu_b;
            fu_c      = (fu_a >= fu_b);
            fu_v      = (fu_a[31] != fu_b[31]) && (fu_result[31] != fu_a[31]);
         end
         4'b0010: fu_result = fu_a & fu_b;
         4'b0110: fu_result = fu_a | fu_b;
         4'b1010: fu_result = fu_a ^ fu_b;
         4'b0001: fu_result = fu_a << fu_b[4:0];
         4'b0101: fu_result = fu_a >> fu_b[4:0];
         4'b1001: fu_result = $unsigned($signed(fu_a) >>> fu_b[4:0]);
         default: fu_result = 32'd0;
      endcase
      fu_z = (fu_result == 32'd0);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one op for a single cycle; returns in the EXEC cycle.
   task automatic issue(input logic [2:0] f3, input logic f7,
                        input logic im, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] iv,
                        input logic [4:0] rd);
      bus.in_valid  = 1'b1;
      bus.funct3    = f3;
      bus.funct7_b5 = f7;
      bus.is_imm    = im;
      bus.rs1_val   = a;
      bus.rs2_val   = b;
      bus.imm       = iv;
      bus.rd        = rd;
      step();
      bus.in_valid  = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      bus.funct3    = 3'd0;
      bus.funct7_b5 = 1'b0;
      bus.is_imm    = 1'b0;
      bus.rs1_val   = 32'd0;
      bus.rs2_val   = 32'd0;
      bus.imm       = 32'd0;
      bus.rd        = 5'd0;
      step();
      step();
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_data", bus.out_data, 32'd0);
      chk("rst_out_flags", 32'(bus.out_flags), 32'd0);
      chk("rst_out_err", 32'(bus.out_err), 32'd0);
      chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
      chk("rst_fu_a", fu_a, 32'd0);
      chk("rst_fu_b", fu_b, 32'd0);
      chk("rst_fu_fs", 32'(fu_fs), 32'd0);
      rst = 1'b0;
      step();

      // ADD 0xFFFFFFFF + 1
      issue(3'b000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 5'd3);
      chk("add_exec_valid", 32'(bus.out_valid), 32'd0);
      chk("add_exec_ready", 32'(bus.in_ready), 32'd0);
      chk("add_fu_a", fu_a, 32'hFFFF_FFFF);
      chk("add_fu_b", fu_b, 32'd1);
      step();
      chk("add_valid", 32'(bus.out_valid), 32'd1);
      chk("add_data", bus.out_data, 32'd0);
      chk("add_flags", 32'(bus.out_flags), 32'b110);
      chk("add_rd", 32'(bus.out_rd), 32'd3);
      chk("add_err", 32'(bus.out_err), 32'd0);
      step();
      chk("add_idle", 32'(bus.in_ready), 32'd1);

      // SLT 0x80000000 < 1 signed
      issue(3'b010, 1'b0, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 5'd4);
      chk("slt_fu_fs", 32'(fu_fs), 32'b1000);
      step();
      chk("slt_cmp_valid", 32'(bus.out_valid), 32'd0);
      step();
      chk("slt_valid", 32'(bus.out_valid), 32'd1);
      chk("slt_data", bus.out_data, 32'd1);
      chk("slt_flags", 32'(bus.out_flags), 32'b011);
      step();

      // SLTU same operands
      issue(3'b011, 1'b0, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 5'd5);
      step();
      step();
      chk("sltu_valid", 32'(bus.out_valid), 32'd1);
      chk("sltu_data", bus.out_data, 32'd0);
      step();

      // SRAI by imm[4:0]=4
      issue(3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'h1234_5678,
            32'h0000_0404, 5'd6);
      chk("srai_fu_b", fu_b, 32'd4);
      chk("srai_fu_fs", 32'(fu_fs), 32'b1001);
      step();
      chk("srai_data", bus.out_data, 32'hF800_0000);
      chk("srai_flags", 32'(bus.out_flags), 32'b000);
      step();

      // SUB 5 - 7 with borrow
      issue(3'b000, 1'b1, 1'b0, 32'd5, 32'd7, 32'd0, 5'd8);
      chk("sub_fu_fs", 32'(fu_fs), 32'b1000);
      step();
      chk("sub_data", bus.out_data, 32'hFFFF_FFFE);
      chk("sub_flags", 32'(bus.out_flags), 32'b000);
      step();

      // ADDI ignores funct7_b5
      issue(3'b000, 1'b1, 1'b1, 32'd5, 32'd100, 32'd3, 5'd9);
      chk("addi_fu_fs", 32'(fu_fs), 32'b0000);
      step();
      chk("addi_data", bus.out_data, 32'd8);
      chk("addi_err", 32'(bus.out_err), 32'd0);
      step();

      // Illegal register op: funct3=100 with funct7_b5
      issue(3'b100, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1111_1111, 32'd0, 5'd10);
      chk("ill_fu_fs", 32'(fu_fs), 32'd0);
      chk("ill_fu_a", fu_a, 32'd0);
      chk("ill_fu_b", fu_b, 32'd0);
      step();
      chk("ill_valid", 32'(bus.out_valid), 32'd1);
      chk("ill_err", 32'(bus.out_err), 32'd1);
      chk("ill_data", bus.out_data, 32'd0);
      chk("ill_flags", 32'(bus.out_flags), 32'd0);
      step();

      // Illegal SLLI with funct7_b5
      issue(3'b001, 1'b1, 1'b1, 32'd1, 32'd0, 32'h0000_0401, 5'd11);
      step();
      chk("slli_ill_err", 32'(bus.out_err), 32'd1);
      step();

      // XOR with 5 cycles of output backpressure
      bus.out_ready = 1'b0;
      issue(3'b100, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 5'd7);
      step();
      for (int i = 0; i < 5; i++) begin
         chk("bp_valid", 32'(bus.out_valid), 32'd1);
         chk("bp_data", bus.out_data, 32'h0FF0_0FF0);
         chk("bp_rd", 32'(bus.out_rd), 32'd7);
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         step();
      end
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.funct3    = 3'b110;
      bus.funct7_b5 = 1'b0;
      bus.is_imm    = 1'b0;
      bus.rs1_val   = 32'h0000_00F0;
      bus.rs2_val   = 32'h0000_000F;
      bus.rd        = 5'd12;
      step();
      chk("hs_idle_ready", 32'(bus.in_ready), 32'd1);
      chk("hs_idle_valid", 32'(bus.out_valid), 32'd0);
      step();
      bus.in_valid = 1'b0;
      chk("resume_fu_a", fu_a, 32'h0000_00F0);
      step();
      chk("resume_data", bus.out_data, 32'h0000_00FF);
      chk("resume_rd", 32'(bus.out_rd), 32'd12);
      step();

      // Reset while in CMP discards the op
      issue(3'b010, 1'b0, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 5'd13);
      step();
      rst          = 1'b1;
      bus.in_valid = 1'b1;
      step();
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      chk("rstcmp_ready", 32'(bus.in_ready), 32'd1);
      chk("rstcmp_valid", 32'(bus.out_valid), 32'd0);
      chk("rstcmp_data", bus.out_data, 32'd0);
      chk("rstcmp_rd", 32'(bus.out_rd), 32'd0);
      step();
      step();
      chk("rstcmp_no_out", 32'(bus.out_valid), 32'd0);
      chk("rstcmp_still_idle", 32'(bus.in_ready), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
